// File: rtl/led_pattern_seq.sv
// Purpose : divides clk_50M to a step rate and animates an LED bank (walk, fill, bounce, blink).
// Latency : a step updates pos on the tick edge; dataout/wrap show the new pos one edge later.
// Backpr. : pause freezes prescaler and animation; a mode change restarts the pattern.
//
// Ports:
//   clk_50M  - system clock, the only clock
//   rst      - asynchronous active-high reset
//   mode     - 0=WALK, 1=FILL, 2=BOUNCE, 3=BLINK (synchronous to clk_50M)
//   pause    - 1 holds the prescaler and the animation state
//   dataout  - registered LED drive (polarity set by ACTIVE_LOW)
//   wrap     - registered one-cycle pulse when a pattern cycle restarts at pos 0
module led_pattern_seq #(
  parameter int LED_W      = 12,
  parameter int TICK_DIV   = 12_500_000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic             clk_50M,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             pause,
  output logic [LED_W-1:0] dataout,
  output logic             wrap
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int POS_W = $clog2(LED_W);

  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(TICK_DIV - 1);
  localparam logic [POS_W-1:0] POS_MAX  = POS_W'(LED_W - 1);
  // BOUNCE turns around one step before each end, so the end
  // positions are shown once per sweep rather than twice.
  localparam logic [POS_W-1:0] POS_TURN = POS_W'(LED_W - 2);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

  localparam bit               AL      = (ACTIVE_LOW != 0);
  localparam logic [LED_W-1:0] LED_OFF = AL ? {LED_W{1'b1}} : {LED_W{1'b0}};

  typedef enum logic [1:0] {
    WALK   = 2'd0,
    FILL   = 2'd1,
    BOUNCE = 2'd2,
    BLINK  = 2'd3
  } mode_t;

  logic [PRE_W-1:0] pre;
  logic [POS_W-1:0] pos;
  logic             dir;
  mode_t            mode_q;
  // Set on the edge a tick lands pos on 0; becomes wrap one edge later so
  // the pulse lines up with the dataout that shows pos 0.
  logic             wrap_arm;

  logic             tick;
  logic             mode_chg;
  logic [POS_W-1:0] pos_nxt;
  logic             dir_nxt;
  logic [LED_W-1:0] lit;
  logic [LED_W-1:0] drive;

  assign tick     = (pre == PRE_MAX) && !pause;
  assign mode_chg = (mode != mode_q);

  // Next step position/direction, used only when tick is taken.
  always_comb begin
    pos_nxt = pos;
    dir_nxt = dir;
    case (mode_q)
      WALK, FILL: begin
        pos_nxt = (pos == POS_MAX) ? '0 : pos + POS_ONE;
      end
      BOUNCE: begin
        if (!dir) begin
          pos_nxt = pos + POS_ONE;
          if (pos == POS_TURN) dir_nxt = 1'b1;
        end else begin
          pos_nxt = pos - POS_ONE;
          if (pos == POS_ONE) dir_nxt = 1'b0;
        end
      end
      BLINK: begin
        pos_nxt = (pos == '0) ? POS_ONE : '0;
      end
      default: begin
        pos_nxt = '0;
        dir_nxt = 1'b0;
      end
    endcase
  end

  // Lit vector from the current (pre-step) state.
  always_comb begin
    lit = '0;
    case (mode_q)
      WALK, BOUNCE: lit = LED_W'(1) << pos;
      // (2 << pos) - 1 gives bits [pos:0]; at pos = LED_W-1 the shift
      // drops out of range to 0 and the subtraction yields all ones.
      FILL:         lit = (LED_W'(2) << pos) - LED_W'(1);
      BLINK:        lit = (pos == '0) ? {LED_W{1'b1}} : {LED_W{1'b0}};
      default:      lit = '0;
    endcase
    drive = AL ? ~lit : lit;
  end

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      pre      <= '0;
      pos      <= '0;
      dir      <= 1'b0;
      mode_q   <= WALK;
      wrap_arm <= 1'b0;
      wrap     <= 1'b0;
      dataout  <= LED_OFF;
    end else begin
      dataout  <= drive;
      wrap     <= wrap_arm;
      wrap_arm <= 1'b0;
      if (mode_chg) begin
        // Restart the new pattern cleanly; beats a coincident tick and pause.
        mode_q <= mode_t'(mode);
        pos    <= '0;
        dir    <= 1'b0;
        pre    <= '0;
      end else if (!pause) begin
        pre <= (pre == PRE_MAX) ? '0 : pre + PRE_W'(1);
        if (tick) begin
          pos      <= pos_nxt;
          dir      <= dir_nxt;
          wrap_arm <= (pos_nxt == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_seq.sv
// Purpose : directed self-checking bench for led_pattern_seq (LED_W=4, active-low).
// Latency : outputs sampled 1 time unit after each rising edge.
// Backpr. : exercises pause and mode changes on one instance, TICK_DIV=1 bounce on another.
module tb_led_pattern_seq;

  logic       clk_50M = 1'b0;
  logic       rst_a, pause_a, rst_b, pause_b;
  logic [1:0] mode_a, mode_b;
  logic [3:0] dout_a, dout_b;
  logic       wrap_a, wrap_b;

  int checks = 0;
  int errors = 0;

  always #5 clk_50M = ~clk_50M;

  led_pattern_seq #(.LED_W(4), .TICK_DIV(3), .ACTIVE_LOW(1)) dut_a (
    .clk_50M (clk_50M),
    .rst     (rst_a),
    .mode    (mode_a),
    .pause   (pause_a),
    .dataout (dout_a),
    .wrap    (wrap_a)
  );

  led_pattern_seq #(.LED_W(4), .TICK_DIV(1), .ACTIVE_LOW(1)) dut_b (
    .clk_50M (clk_50M),
    .rst     (rst_b),
    .mode    (mode_b),
    .pause   (pause_b),
    .dataout (dout_b),
    .wrap    (wrap_b)
  );

  task automatic chk(input string tag, input logic [3:0] got_d, input logic got_w,
                     input logic [3:0] exp_d, input logic exp_w);
    checks++;
    assert (got_d === exp_d) else begin
      errors++;
      $error("FAIL %s dataout observed %b expected %b", tag, got_d, exp_d);
    end
    checks++;
    assert (got_w === exp_w) else begin
      errors++;
      $error("FAIL %s wrap observed %b expected %b", tag, got_w, exp_w);
    end
  endtask

  task automatic step_a(input string tag, input logic [3:0] exp_d, input logic exp_w);
    @(posedge clk_50M);
    #1;
    chk(tag, dout_a, wrap_a, exp_d, exp_w);
  endtask

  task automatic run_a(input string tag, input logic [3:0] exp_d, input int n);
    for (int i = 0; i < n; i++) step_a(tag, exp_d, 1'b0);
  endtask

  task automatic step_b(input string tag, input logic [3:0] exp_d, input logic exp_w);
    @(posedge clk_50M);
    #1;
    chk(tag, dout_b, wrap_b, exp_d, exp_w);
  endtask

  initial begin
    rst_a = 1'b1; mode_a = 2'd0; pause_a = 1'b0;
    rst_b = 1'b1; mode_b = 2'd2; pause_b = 1'b0;
    #3;
    chk("reset_a", dout_a, wrap_a, 4'b1111, 1'b0);
    chk("reset_b", dout_b, wrap_b, 4'b1111, 1'b0);
    @(posedge clk_50M);
    #1;
    rst_a = 1'b0;

    // WALK: each step held 3 cycles, wrap with the return to pos 0
    run_a("walk_p0", 4'b1110, 3);
    run_a("walk_p1", 4'b1101, 3);
    run_a("walk_p2", 4'b1011, 3);
    run_a("walk_p3", 4'b0111, 3);
    step_a("walk_wrap", 4'b1110, 1'b1);

    // FILL: switch edge still shows the old WALK pos 0, then the fill sequence
    mode_a = 2'd1;
    step_a("fill_switch", 4'b1110, 1'b0);
    run_a("fill_p0", 4'b1110, 3);
    run_a("fill_p1", 4'b1100, 3);
    run_a("fill_p2", 4'b1000, 3);
    run_a("fill_p3", 4'b0000, 3);
    step_a("fill_wrap", 4'b1110, 1'b1);

    // async reset while wrap is high clears everything at once
    rst_a = 1'b1; mode_a = 2'd0;
    #1;
    chk("reset_mid", dout_a, wrap_a, 4'b1111, 1'b0);
    @(posedge clk_50M);
    #1;
    rst_a = 1'b0;

    // mode switch on the cycle where pre==2 with WALK at pos 2
    run_a("coin_p0", 4'b1110, 3);
    run_a("coin_p1", 4'b1101, 3);
    step_a("coin_p2a", 4'b1011, 1'b0);
    step_a("coin_p2b", 4'b1011, 1'b0);
    mode_a = 2'd1;
    step_a("coin_old", 4'b1011, 1'b0);
    run_a("coin_new", 4'b1110, 3);
    step_a("coin_next", 4'b1100, 1'b0);

    // BLINK with a 10-cycle pause one cycle into an "on" period
    mode_a = 2'd3;
    step_a("blink_switch", 4'b1100, 1'b0);
    run_a("blink_on", 4'b0000, 3);
    run_a("blink_off", 4'b1111, 3);
    step_a("blink_wrap", 4'b0000, 1'b1);
    pause_a = 1'b1;
    run_a("pause_hold", 4'b0000, 10);
    pause_a = 1'b0;
    run_a("pause_resume", 4'b0000, 2);
    step_a("blink_toggle", 4'b1111, 1'b0);

    // BOUNCE up to pos 3 and back to pos 2 (dir=1), then async reset pulse
    mode_a = 2'd2;
    step_a("bounce_switch", 4'b1111, 1'b0);
    run_a("bounce_p0", 4'b1110, 3);
    run_a("bounce_p1", 4'b1101, 3);
    run_a("bounce_p2", 4'b1011, 3);
    run_a("bounce_p3", 4'b0111, 3);
    step_a("bounce_down2", 4'b1011, 1'b0);
    #2;
    rst_a = 1'b1; mode_a = 2'd0;
    #1;
    chk("async_reset", dout_a, wrap_a, 4'b1111, 1'b0);
    #1;
    rst_a = 1'b0;
    run_a("restart_p0", 4'b1110, 3);
    step_a("restart_p1", 4'b1101, 1'b0);

    // TICK_DIV=1 BOUNCE: mode change on first edge, then one position per cycle
    rst_b = 1'b0;
    step_b("b_switch", 4'b1110, 1'b0);
    step_b("b_pos0", 4'b1110, 1'b0);
    step_b("b_pos1", 4'b1101, 1'b0);
    step_b("b_pos2", 4'b1011, 1'b0);
    step_b("b_pos3", 4'b0111, 1'b0);
    step_b("b_pos2d", 4'b1011, 1'b0);
    step_b("b_pos1d", 4'b1101, 1'b0);
    step_b("b_pos0w", 4'b1110, 1'b1);
    step_b("b_pos1u", 4'b1101, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_pattern_seq.md
# led_pattern_seq

Parametrised LED pattern sequencer for the board's LED bank. It divides `clk_50M` down to a step rate and drives one of four selectable animations: walk, fill, bounce or blink. Mode can change at run time, and a pause input freezes the animation. It replaces the fixed 16-step LED-water table and sits directly between the board clock and the LED pins; a one-cycle `wrap` pulse is available to other logic.

## Interface
- `LED_W`, 12: number of LEDs; legal range ≥2.
- `TICK_DIV`, 12_500_000: `clk_50M` cycles per animation step; legal range ≥1.
- `ACTIVE_LOW`, 1: 1 means a lit LED is driven 0 (board default); 0 means a lit LED is driven 1.
- `clk_50M`  input  1  system clock, the only clock.
- `rst`  input  1  asynchronous, active-high reset.
- `mode`  input  2  0=WALK, 1=FILL, 2=BOUNCE, 3=BLINK; synchronous to `clk_50M`.
- `pause`  input  1  1 holds the prescaler and the animation state.
- `dataout`  output  LED_W  registered LED drive.
- `wrap`  output  1  registered one-cycle pulse when a pattern cycle restarts.

## Operation
- Prescaler `pre` has width clog2(TICK_DIV), minimum 1.
  - `pre` counts 0..TICK_DIV-1, then wraps to 0.
  - `tick` = (pre==TICK_DIV-1) && !pause.
  - While pause=1, `pre` holds.
- Step state: `pos` (width clog2(LED_W)), `dir` (0=up), `mode_q` (the registered mode).
- Mode change: in any cycle where mode != mode_q, load mode_q<=mode, pos<=0, dir<=0, pre<=0.
  - This takes priority over tick and over pause.
  - No wrap is issued on a mode change.
- On tick, per mode_q:
  - WALK: pos<=pos+1; at LED_W-1, pos<=0.
  - FILL: same stepping as WALK.
  - BOUNCE, dir=0: pos<=pos+1. When pos==LED_W-2, also set dir<=1.
  - BOUNCE, dir=1: pos<=pos-1. When pos==1, also set dir<=0.
  - BOUNCE therefore visits 0,1,…,W-1,W-2,…,1,0,… and never repeats an end position.
  - BLINK: pos toggles between 0 and 1.
- Lit vector L (1 = on), computed from mode_q and pos:
  - WALK and BOUNCE: only bit pos set.
  - FILL: bits [pos:0] set.
  - BLINK: all ones when pos==0, all zeros when pos==1.
- Outputs:
  - dataout <= ACTIVE_LOW ? ~L : L.
  - wrap <= 1 in the cycle after a tick that moves pos to 0; otherwise wrap <= 0.
- Arithmetic: pos never exceeds LED_W-1. All comparisons are unsigned. No out-of-range states are reachable.

## Timing
- Reset values (asynchronous, applied immediately): pre=0, pos=0, dir=0, mode_q=0, wrap=0. dataout = all LEDs off (all ones when ACTIVE_LOW=1).
- First rising edge after rst deasserts: dataout shows the mode_q=0 (WALK) pattern with pos=0.
  - If mode != 0 at that edge, the mode-change rule applies first and the pattern appears one edge later.
- Latency: tick at edge N updates pos at edge N; dataout and wrap reflect the new pos at edge N+1.
- Step period: exactly TICK_DIV cycles while pause=0. TICK_DIV=1 steps every cycle.
- Pause: dataout holds its value. Releasing pause resumes from the held pre; no step is lost or duplicated.
- Reset asserted mid-sequence: all state returns to the reset values at once. No wrap pulse is generated.
- Mode change in the same cycle as a tick: the mode change wins; pos=0 and the tick is discarded.
- Mode input is assumed synchronous; the block does not synchronise it.

## Test plan
- Reset and WALK (LED_W=4, TICK_DIV=3, ACTIVE_LOW=1, mode=0): deassert rst.
  - Expect dataout 1110 for 3 cycles, then 1101, 1011, 0111, 1110.
  - Expect wrap high for exactly one cycle, together with the return to 1110.
- FILL (mode=1, same parameters):
  - Expect the sequence 1110, 1100, 1000, 0000, 1110, each held 3 cycles.
- BOUNCE (mode=2, LED_W=4, TICK_DIV=1):
  - Expect active-low positions 0,1,2,3,2,1,0,1, one per cycle.
  - Expect wrap only when the position returns to 0.
- BLINK plus pause (mode=3, TICK_DIV=3): dataout alternates 0000 and 1111 every 3 cycles.
  - Assert pause for 10 cycles mid-period: dataout is frozen for all 10.
  - After release, the remaining cycles of the interrupted period complete before the next toggle.
- Mode switch coincident with tick (WALK at pos=2, switch to FILL on the cycle where pre==2):
  - Next dataout is 1110.
  - No wrap pulse.
  - The following step comes 3 cycles later.
- Async reset mid-BOUNCE (dir=1, pos=2): pulse rst between clock edges.
  - dataout goes to 1111 before the next edge.
  - Afterwards WALK restarts from 1110, with wrap=0 throughout.
